// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder_if
// Multiplexed seven-segment display bus (active-low segments and anodes).
//   seg[7:0] : segment lines, seg[0]=a .. seg[6]=g, seg[7]=dp
//   an[3:0]  : anode enables, an[3]=minutes tens .. an[0]=seconds units
// Modports:
//   master : the display driver (drives seg/an)
//   slave  : a passive observer such as seg_scan_decoder
// ---------------------------------------------------------------------------
interface seg_scan_decoder_if;
   logic [7:0] seg;
   logic [3:0] an;

   modport master (output seg, output an);
   modport slave  (input  seg, input  an);
endinterface

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Passive monitor for a 4-digit multiplexed seven-segment bus. It waits for
// each scan step to settle, decodes the lit digit into its slot, and when all
// four slots have been refreshed publishes an MM:SS frame together with its
// value in elapsed seconds.
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset
//   bus           : display bus observed through the slave modport
//   digits        : last complete frame, digits[15:12]=an[3] slot .. [3:0]=an[0]
//   frame_valid   : one-clock pulse when digits updates
//   frame_changed : pulse with frame_valid when the frame differs from the last
//   frame_err     : last frame held an undecodable pattern (code 4'hE)
//   total_sec     : MM*60+SS of the last numeric, in-range frame
//   total_valid   : last frame was numeric and in range
//   stale         : no digit captured for TIMEOUT_CYCLES clocks
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   seg_scan_decoder_if.slave        bus,
   output logic [15:0]              digits,
   output logic                     frame_valid,
   output logic                     frame_changed,
   output logic                     frame_err,
   output logic [11:0]              total_sec,
   output logic                     total_valid,
   output logic                     stale
);

   localparam int SW = $clog2(STABLE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

   // -----------------------------------------------------------------------
   // Helpers
   // -----------------------------------------------------------------------
   function automatic logic [3:0] decode_seg(input logic [6:0] pat);
      logic [3:0] code;
      case (pat)
         7'h40:   code = 4'h0;
         7'h79:   code = 4'h1;
         7'h24:   code = 4'h2;
         7'h30:   code = 4'h3;
         7'h19:   code = 4'h4;
         7'h12:   code = 4'h5;
         7'h02:   code = 4'h6;
         7'h78:   code = 4'h7;
         7'h00:   code = 4'h8;
         7'h10:   code = 4'h9;
         7'h7F:   code = 4'hF;
         default: code = 4'hE;
      endcase
      return code;
   endfunction

   function automatic logic is_single_low(input logic [3:0] a);
      logic hit;
      case (a)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
         default:                            hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic [1:0] slot_of(input logic [3:0] a);
      logic [1:0] idx;
      case (a)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // d*10 as d*8 + d*2; only ever applied to codes 0..9.
   function automatic logic [6:0] times10(input logic [3:0] d);
      return {d, 3'b000} + {2'b00, d, 1'b0};
   endfunction

   // (tens*10+units) for minutes, then *60 as *64 - *4, plus seconds.
   function automatic logic [11:0] to_seconds(input logic [15:0] f);
      logic [6:0]  mm;
      logic [6:0]  ss;
      logic [12:0] sum;
      mm  = times10(f[15:12]) + {3'b000, f[11:8]};
      ss  = times10(f[7:4])   + {3'b000, f[3:0]};
      sum = {mm, 6'b000000} - {4'b0000, mm, 2'b00} + {6'b000000, ss};
      return sum[11:0];
   endfunction

   function automatic logic in_range(input logic [15:0] f);
      return (f[15:12] <= 4'd5) && (f[11:8] <= 4'd9) &&
             (f[7:4]   <= 4'd5) && (f[3:0]  <= 4'd9);
   endfunction

   function automatic logic has_invalid(input logic [15:0] f);
      return (f[15:12] == 4'hE) || (f[11:8] == 4'hE) ||
             (f[7:4]   == 4'hE) || (f[3:0]  == 4'hE);
   endfunction

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [10:0]   prev_r;
   logic [SW-1:0] stab_cnt_r;
   logic          dwell_cap_r;
   logic [3:0]    seen_r;
   logic [15:0]   slots_r;
   logic          done_r;
   logic [TW-1:0] tmo_cnt_r;
   logic [15:0]   digits_r;
   logic          frame_valid_r;
   logic          frame_changed_r;
   logic          frame_err_r;
   logic [11:0]   total_sec_r;
   logic          total_valid_r;
   logic          stale_r;

   logic [10:0]   sample_s;
   logic          same_s;
   logic [SW-1:0] stab_nxt_s;
   logic          dwell_nxt_s;
   logic          cap_s;
   logic [1:0]    slot_s;
   logic [3:0]    slot_mask_s;
   logic          frame_done_s;
   logic [TW-1:0] tmo_nxt_s;
   logic          tmo_hit_s;

   // Stability tracking, capture qualification and timeout next-state.
   always_comb begin
      sample_s = {bus.an, bus.seg[6:0]};
      same_s   = (sample_s == prev_r);

      if (!same_s) begin
         stab_nxt_s = '0;
      end else if (stab_cnt_r == STB_LAST) begin
         stab_nxt_s = stab_cnt_r;
      end else begin
         stab_nxt_s = stab_cnt_r + SW'(1);
      end

      slot_s      = slot_of(bus.an);
      // With exactly one anode low, its inversion is the one-hot slot mask.
      slot_mask_s = ~bus.an;
      cap_s       = is_single_low(bus.an) && !dwell_cap_r && (stab_nxt_s == STB_LAST);

      if (!same_s) begin
         dwell_nxt_s = 1'b0;
      end else if (cap_s) begin
         dwell_nxt_s = 1'b1;
      end else begin
         dwell_nxt_s = dwell_cap_r;
      end

      frame_done_s = cap_s && ((seen_r | slot_mask_s) == 4'hF);

      if (cap_s) begin
         tmo_nxt_s = '0;
      end else if (tmo_cnt_r == TMO_LAST) begin
         tmo_nxt_s = tmo_cnt_r;
      end else begin
         tmo_nxt_s = tmo_cnt_r + TW'(1);
      end
      tmo_hit_s = (tmo_nxt_s == TMO_LAST);
   end

   // Capture pipeline, frame assembly and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_r          <= 11'h000;
         stab_cnt_r      <= '0;
         dwell_cap_r     <= 1'b0;
         seen_r          <= 4'h0;
         slots_r         <= 16'hFFFF;
         done_r          <= 1'b0;
         tmo_cnt_r       <= '0;
         digits_r        <= 16'hFFFF;
         frame_valid_r   <= 1'b0;
         frame_changed_r <= 1'b0;
         frame_err_r     <= 1'b0;
         total_sec_r     <= 12'd0;
         total_valid_r   <= 1'b0;
         stale_r         <= 1'b0;
      end else begin
         prev_r          <= sample_s;
         stab_cnt_r      <= stab_nxt_s;
         dwell_cap_r     <= dwell_nxt_s;
         tmo_cnt_r       <= tmo_nxt_s;
         done_r          <= frame_done_s;
         frame_valid_r   <= 1'b0;
         frame_changed_r <= 1'b0;

         if (cap_s) begin
            slots_r[{slot_s, 2'b00} +: 4] <= decode_seg(bus.seg[6:0]);
         end

         // Seen is cleared as soon as the last slot lands; the next capture
         // cannot occur before the frame is published one clock later.
         if (frame_done_s) begin
            seen_r <= 4'h0;
         end else if (cap_s) begin
            seen_r <= seen_r | slot_mask_s;
         end else if (tmo_hit_s) begin
            seen_r <= 4'h0;
         end

         if (tmo_hit_s) begin
            stale_r <= 1'b1;
         end

         // Publish the frame assembled on the previous clock.
         if (done_r) begin
            digits_r        <= slots_r;
            frame_valid_r   <= 1'b1;
            frame_changed_r <= (slots_r != digits_r);
            frame_err_r     <= has_invalid(slots_r);
            stale_r         <= 1'b0;
            if (in_range(slots_r)) begin
               total_sec_r   <= to_seconds(slots_r);
               total_valid_r <= 1'b1;
            end else begin
               total_valid_r <= 1'b0;
            end
         end
      end
   end

   assign digits        = digits_r;
   assign frame_valid   = frame_valid_r;
   assign frame_changed = frame_changed_r;
   assign frame_err     = frame_err_r;
   assign total_sec     = total_sec_r;
   assign total_valid   = total_valid_r;
   assign stale         = stale_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
// Directed scan patterns on the display bus. A run-length based model of the
// display protocol predicts every output on every clock, and literal values
// after each scenario pin the model down.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

   localparam int STABLE = 4;
   localparam int TMO    = 50;
   localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic        clk;
   logic        rst_n;
   logic [15:0] digits;
   logic        frame_valid;
   logic        frame_changed;
   logic        frame_err;
   logic [11:0] total_sec;
   logic        total_valid;
   logic        stale;

   int errors = 0;
   int checks = 0;
   int fv_cnt = 0;
   int fc_cnt = 0;

   seg_scan_decoder_if bus ();

   seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.slave),
      .digits        (digits),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .frame_err     (frame_err),
      .total_sec     (total_sec),
      .total_valid   (total_valid),
      .stale         (stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Segment byte for a digit: 0..9 numeric, 15 blank, anything else a broken pattern.
   function automatic logic [7:0] seg_for(input int d);
      logic [6:0] p;
      if (d >= 0 && d <= 9) p = PAT[d];
      else if (d == 15)     p = 7'h7F;
      else                  p = 7'h7E;
      return {1'b1, p};
   endfunction

   function automatic int model_decode(input logic [6:0] p);
      for (int k = 0; k < 10; k++) begin
         if (p == PAT[k]) return k;
      end
      if (p == 7'h7F) return 15;
      return 14;
   endfunction

   // Called at a falling edge; holds the pattern for n rising edges.
   task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
      bus.an  = a;
      bus.seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input int d3, input int d2, input int d1, input int d0);
      dwell(4'b0111, seg_for(d3), 8);
      dwell(4'b1011, seg_for(d2), 8);
      dwell(4'b1101, seg_for(d1), 8);
      dwell(4'b1110, seg_for(d0), 8);
   endtask

   // Each dwell opens with a one-clock wrong (but decodable) pattern.
   task automatic glitch_scan(input int d3, input int d2, input int d1, input int d0);
      int d [4];
      d = '{d0, d1, d2, d3};
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] a;
         a = 4'hF;
         a[i] = 1'b0;
         dwell(a, seg_for(8), 1);
         dwell(a, seg_for(d[i]), 6);
      end
   endtask

   // Model + per-cycle compare.
   initial begin : model
      logic [10:0] cur;
      logic [10:0] last;
      bit          have_last;
      int          run;
      int          idle;
      bit          seen [4];
      int          md [4];
      bit          pend;
      int          slot;
      int          zeros;
      bit          ok;
      logic [15:0] nf;
      logic [15:0] e_digits;
      logic        e_fv, e_fc, e_err, e_tv, e_stale;
      logic [11:0] e_total;
      forever begin
         @(posedge clk);
         cur = {bus.an, bus.seg[6:0]};
         if (!rst_n) begin
            have_last = 1'b0; run = 0; idle = 0; pend = 1'b0;
            for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; md[i] = 15; end
            e_digits = 16'hFFFF; e_fv = 1'b0; e_fc = 1'b0; e_err = 1'b0;
            e_total = 12'd0; e_tv = 1'b0; e_stale = 1'b0;
         end else begin
            e_fv = 1'b0;
            e_fc = 1'b0;
            if (pend) begin
               nf = {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
               e_fv = 1'b1;
               e_fc = (nf != e_digits);
               e_digits = nf;
               e_err = 1'b0;
               ok = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  if (md[i] == 14) e_err = 1'b1;
                  if (md[i] > 9) ok = 1'b0;
               end
               if (md[3] > 5 || md[1] > 5) ok = 1'b0;
               if (ok) begin
                  e_total = 12'((md[3] * 10 + md[2]) * 60 + md[1] * 10 + md[0]);
                  e_tv = 1'b1;
               end else begin
                  e_tv = 1'b0;
               end
               e_stale = 1'b0;
               pend = 1'b0;
            end
            if (have_last && cur == last) run++;
            else run = 1;
            last = cur;
            have_last = 1'b1;
            zeros = 0;
            slot = -1;
            for (int i = 0; i < 4; i++) begin
               if (!cur[7 + i]) begin zeros++; slot = i; end
            end
            if (run == STABLE && zeros == 1) begin
               md[slot] = model_decode(cur[6:0]);
               seen[slot] = 1'b1;
               idle = 0;
               if (seen[0] && seen[1] && seen[2] && seen[3]) begin
                  pend = 1'b1;
                  for (int i = 0; i < 4; i++) seen[i] = 1'b0;
               end
            end else begin
               if (idle < TMO) idle++;
               if (idle == TMO) begin
                  e_stale = 1'b1;
                  for (int i = 0; i < 4; i++) seen[i] = 1'b0;
               end
            end
         end
         #1;
         chk("cyc_digits", 32'(digits), 32'(e_digits));
         chk("cyc_frame_valid", 32'(frame_valid), 32'(e_fv));
         chk("cyc_frame_changed", 32'(frame_changed), 32'(e_fc));
         chk("cyc_frame_err", 32'(frame_err), 32'(e_err));
         chk("cyc_total_sec", 32'(total_sec), 32'(e_total));
         chk("cyc_total_valid", 32'(total_valid), 32'(e_tv));
         chk("cyc_stale", 32'(stale), 32'(e_stale));
         if (frame_valid === 1'b1) fv_cnt++;
         if (frame_changed === 1'b1) fc_cnt++;
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_digits"}, 32'(digits), 32'hFFFF);
      chk({tag, "_fv"}, 32'(frame_valid), 32'h0);
      chk({tag, "_fc"}, 32'(frame_changed), 32'h0);
      chk({tag, "_err"}, 32'(frame_err), 32'h0);
      chk({tag, "_total"}, 32'(total_sec), 32'h0);
      chk({tag, "_tv"}, 32'(total_valid), 32'h0);
      chk({tag, "_stale"}, 32'(stale), 32'h0);
   endtask

   initial begin : stim
      int fv_snap;
      rst_n   = 1'b0;
      bus.an  = 4'hF;
      bus.seg = 8'hFF;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      rst_n = 1'b1;

      // Static "12:34", two full scans.
      scan(1, 2, 3, 4);
      scan(1, 2, 3, 4);
      chk("s1234_digits", 32'(digits), 32'h1234);
      chk("s1234_total", 32'(total_sec), 32'd754);
      chk("s1234_tv", 32'(total_valid), 32'h1);
      chk("s1234_fv_cnt", 32'(fv_cnt), 32'd2);
      chk("s1234_fc_cnt", 32'(fc_cnt), 32'd1);

      // Glitched dwell starts: only the settled digit may land.
      glitch_scan(1, 2, 3, 4);
      chk("glitch_digits", 32'(digits), 32'h1234);
      chk("glitch_fv_cnt", 32'(fv_cnt), 32'd3);
      chk("glitch_fc_cnt", 32'(fc_cnt), 32'd1);

      scan(5, 9, 5, 9);
      chk("s5959_total", 32'(total_sec), 32'd3599);
      chk("s5959_tv", 32'(total_valid), 32'h1);
      scan(0, 0, 0, 0);
      chk("s0000_total", 32'(total_sec), 32'd0);
      chk("s0000_fc_cnt", 32'(fc_cnt), 32'd3);
      scan(1, 2, 3, 4);

      // Blank minutes tens: not numeric, total holds.
      scan(15, 2, 3, 4);
      chk("blank_digits", 32'(digits), 32'hF234);
      chk("blank_tv", 32'(total_valid), 32'h0);
      chk("blank_total", 32'(total_sec), 32'd754);
      chk("blank_err", 32'(frame_err), 32'h0);

      // Broken pattern 7E on seconds units.
      scan(1, 2, 3, 14);
      chk("bad_digits", 32'(digits), 32'h123E);
      chk("bad_err", 32'(frame_err), 32'h1);
      chk("bad_tv", 32'(total_valid), 32'h0);

      // Minutes tens out of range.
      scan(7, 1, 0, 0);
      chk("s7100_digits", 32'(digits), 32'h7100);
      chk("s7100_tv", 32'(total_valid), 32'h0);
      chk("s7100_err", 32'(frame_err), 32'h0);

      // Partial frame, then scanning stops long enough to go stale.
      dwell(4'b0111, seg_for(1), 8);
      dwell(4'b1011, seg_for(2), 8);
      dwell(4'hF, 8'hFF, 40);
      chk("pre_stale", 32'(stale), 32'h0);
      dwell(4'hF, 8'hFF, 20);
      chk("stale_set", 32'(stale), 32'h1);
      fv_snap = fv_cnt;
      // The earlier partial slots were dropped, so these two cannot finish a frame.
      dwell(4'b1101, seg_for(3), 8);
      dwell(4'b1110, seg_for(4), 8);
      chk("stale_no_frame", 32'(fv_cnt), 32'(fv_snap));
      chk("stale_still", 32'(stale), 32'h1);
      // Slots 1/0 already hold 3/4: the frame completes on the slot 2 capture.
      scan(0, 1, 0, 5);
      chk("resume_digits", 32'(digits), 32'h0134);
      chk("resume_total", 32'(total_sec), 32'd94);
      chk("resume_stale", 32'(stale), 32'h0);
      scan(0, 1, 0, 5);
      chk("resume2_digits", 32'(digits), 32'h0105);
      chk("resume2_total", 32'(total_sec), 32'd65);

      // Reset in the middle of a scan.
      dwell(4'b0111, seg_for(2), 8);
      rst_n = 1'b0;
      dwell(4'b1011, seg_for(3), 2);
      rst_n = 1'b1;
      chk_reset_state("midrst");
      fv_snap = fv_cnt;
      dwell(4'b1011, seg_for(3), 6);
      dwell(4'b1101, seg_for(4), 8);
      dwell(4'b1110, seg_for(5), 8);
      chk("midrst_no_frame", 32'(fv_cnt), 32'(fv_snap));
      chk("midrst_digits", 32'(digits), 32'hFFFF);
      scan(2, 3, 4, 5);
      chk("post_rst_digits", 32'(digits), 32'h2345);
      chk("post_rst_total", 32'(total_sec), 32'd1425);
      chk("post_rst_fv", 32'(fv_cnt), 32'(fv_snap + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
